// File: rtl/seq_det_pkg.sv
// Shared types and constants for the parameterised serial sequence detector.
package seq_det_pkg;

    // Detector FSM states: UNCFG holds no usable pattern, RUN is detecting.
    typedef enum logic {
        UNCFG = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Shortest pattern the detector accepts.
    localparam int MIN_LEN = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping; clr wins over inc.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    // Count register: async clear, sync clear, then saturating increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Run-time configurable serial pattern detector with Mealy match flag,
// overlapping / non-overlapping modes and a saturating match counter.
//
// Handshake: x is consumed on a rising edge only when x_valid=1, the FSM is in
// RUN and cfg_load=0. cfg_load always takes priority; the x offered in that
// same cycle is dropped. There is no backpressure.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 16,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               x_valid,
    input  logic               x,
    output logic               z,
    output logic               armed,
    output logic               cfg_err,
    output logic [CNT_W-1:0]   match_cnt,
    output state_e             dbg_state
);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               cfg_err_q, cfg_err_d;

    logic               len_ok;
    logic               z_c;
    logic               cnt_inc;
    logic               cnt_clr;
    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] mask;
    logic               fill_ok;

    assign len_ok = (cfg_len >= LEN_W'(MIN_LEN)) && (cfg_len <= LEN_W'(MAX_LEN));

    // State register: FSM state, latched configuration, history and fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= UNCFG;
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            hist_q    <= '0;
            fill_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Next-state logic: configuration load has priority over data shifting.
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        cfg_err_d = cfg_err_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        if (cfg_load) begin
            cnt_clr = 1'b1;
            hist_d  = '0;
            fill_d  = '0;
            if (len_ok) begin
                state_d   = RUN;
                pattern_d = cfg_pattern;
                len_d     = cfg_len;
                overlap_d = cfg_overlap;
                cfg_err_d = 1'b0;
            end else begin
                state_d   = UNCFG;
                cfg_err_d = 1'b1;
            end
        end else if ((state_q == RUN) && x_valid) begin
            hist_d  = {hist_q[MAX_LEN-2:0], x};
            cnt_inc = z_c;
            if (z_c && !overlap_q) begin
                // Non-overlapping: the matched bits may not seed the next match.
                fill_d = '0;
            end else if (fill_q != LEN_W'(MAX_LEN)) begin
                fill_d = fill_q + LEN_W'(1);
            end
        end
    end

    // Output logic: Mealy match over {history, x} masked to the active length.
    always_comb begin
        cand    = {hist_q[MAX_LEN-2:0], x};
        mask    = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
        fill_ok = ((int'(fill_q) + 1) >= int'(len_q));
        z_c     = (state_q == RUN) && x_valid && !cfg_load && fill_ok &&
                  (((cand ^ pattern_q) & mask) == '0);
        armed   = (state_q == RUN);
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .cnt   (match_cnt)
    );

    assign z         = z_c;
    assign cfg_err   = cfg_err_q;
    assign dbg_state = state_q;

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 8, giving the maximum pattern length in bits (legal range 2..32).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the match-counter width.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cfg_load  input  1  single-cycle strobe; captures cfg_pattern, cfg_len and cfg_overlap.
REQ-006 cfg_pattern  input  MAX_LEN  target sequence; bit [cfg_len-1] is received first, bit [0] last.
REQ-007 cfg_len  input  $clog2(MAX_LEN+1)  active pattern length.
REQ-008 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping detection.
REQ-009 x_valid  input  1  qualifies x; x is ignored when low.
REQ-010 x  input  1  serial data bit.
REQ-011 z  output  1  Mealy match flag, combinational from registered state and the current x/x_valid.
REQ-012 armed  output  1  registered; high while the block holds a valid configuration.
REQ-013 cfg_err  output  1  registered; high after a rejected cfg_load.
REQ-014 match_cnt  output  CNT_W  registered count of matches, saturating.

Function
REQ-015 The FSM SHALL have two states, UNCFG and RUN; armed SHALL be 1 exactly in RUN.
REQ-016 cfg_load with 2 <= cfg_len <= MAX_LEN SHALL latch the configuration, clear history, fill and match_cnt, clear cfg_err and enter RUN on the next edge; this applies from either state.
REQ-017 cfg_load with cfg_len < 2 or cfg_len > MAX_LEN SHALL set cfg_err, clear history, fill and match_cnt, and enter UNCFG.
REQ-018 In RUN, each cycle with x_valid=1 SHALL shift x into the LSB of the MAX_LEN-bit history register, shifting the older bits left.
REQ-019 In RUN, each such cycle SHALL increment fill, saturating at MAX_LEN.
REQ-020 z SHALL be 1 iff state is RUN, x_valid=1, cfg_load=0, fill+1 >= len, and the low len bits of {history, x} equal the low len bits of the pattern.
REQ-021 z SHALL have zero-cycle latency: it asserts in the same cycle as the last pattern bit.
REQ-022 On a match with overlap=1, history and fill SHALL update normally, so suffix bits may begin the next match.
REQ-023 On a match with overlap=0, fill SHALL be cleared to 0 on that edge, so no bit of a matched sequence is reused.
REQ-024 Cycles with x_valid=0 SHALL leave history, fill and match_cnt unchanged and hold z at 0; gaps are transparent to detection.
REQ-025 match_cnt SHALL increment by 1 on each cycle z=1.
REQ-026 match_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-027 When cfg_load and x_valid are both high in a cycle, cfg_load SHALL win: x is discarded and z=0.
REQ-028 In UNCFG, z SHALL be 0, and history, fill and match_cnt SHALL hold 0.

Reset
REQ-029 Assertion of rst_n low SHALL immediately force state=UNCFG and clear history, fill, match_cnt, cfg_err and the latched configuration, leaving armed=0 and z=0.
REQ-030 Reset asserted mid-stream SHALL discard any partial match; after release, a new cfg_load is required before detection resumes.

Structure
REQ-031 Package seq_det_pkg SHALL hold the state_e enum (UNCFG, RUN) and the MIN_LEN=2 constant.
REQ-032 The saturating counter SHALL be a sub-module, sat_counter, parameterised by width, with inputs inc and clr.

Verification
REQ-033 Overlap test: MAX_LEN=8; load pattern 4'b1101, len=4, overlap=1; stream 1,1,0,1,1,0,1 -> z=1 on bits 4 and 7; match_cnt=2.
REQ-034 Non-overlap test: same load with overlap=0; stream 1,1,0,1,1,0,1 -> z=1 on bit 4 only; match_cnt=1. Then pattern 2'b11, len=2, stream 1,1,1 -> z on bit 2 only (overlap=1 -> z on bits 2 and 3).
REQ-035 Gap test: pattern 1101, with x_valid=0 gaps of 1-3 cycles between every bit -> z=1 on the 4th valid bit; z=0 in all gap cycles.
REQ-036 Config-error test: cfg_len=1 or cfg_len=9 -> cfg_err=1, armed=0, z stays 0 for any stream. A following valid load -> cfg_err=0, armed=1.
REQ-037 Saturation test: CNT_W=2, pattern 11, overlap=1, stream of six 1s -> 5 matches, match_cnt=3 with no wrap.
REQ-038 Mid-stream reset and collision test: reset after 1,1,0 -> armed=0, match_cnt=0. cfg_load and x_valid in the same cycle -> x not shifted, z=0.
